tree_bitmap_draw: RTL and testbench

Pixel-stream reader for the 32×32 tree sprite colour array. It sits between the VGA pixel scanner and the object-priority mux. Each cycle it converts the current scan coordinate into a sprite offset and looks up the packed colour array. It then issues a draw request plus an 8-bit RGB value two cycles later. A frame-synchronised shake state machine jitters the sprite horizontally after a hit.

---
 rtl/tree_bitmap_draw_pkg.sv | 33 +++
 rtl/tree_bitmap_draw_if.sv | 25 ++
 rtl/tree_bitmap_draw_shake_fsm.sv | 75 +++++++
 rtl/tree_bitmap_draw.sv | 82 ++++++++
 tb/tb_tree_bitmap_draw.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/tree_bitmap_draw_pkg.sv
// Shared constants, types and helpers for the tree sprite reader and its shake FSM.
// Coordinates are widened to 12-bit signed so a sprite shifted past x=0 stays ordered.
package tree_pkg;

  localparam int                  OBJECT_WIDTH_X       = 32;
  localparam int                  OBJECT_HEIGHT_Y      = 32;
  localparam logic [7:0]          TRANSPARENT_ENCODING = 8'hFF;
  localparam int                  COLOR_W              = 8;
  localparam int                  PIX_W                = 11;
  localparam int                  COORD_W              = 12;

  typedef logic [0:OBJECT_HEIGHT_Y-1][0:OBJECT_WIDTH_X-1][COLOR_W-1:0] tree_colors_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHAKE = 1'b1
  } shake_state_t;

  // Zero-extend an unsigned screen coordinate into the signed compare domain.
  function automatic logic signed [COORD_W-1:0] to_coord(input logic [PIX_W-1:0] p);
    return $signed({1'b0, p});
  endfunction

  // Half-open span test lo <= p < lo+span, evaluated in 12-bit signed arithmetic.
  function automatic logic in_span(input logic signed [COORD_W-1:0] p,
                                   input logic signed [COORD_W-1:0] lo,
                                   input int                        span);
    logic signed [COORD_W-1:0] hi;
    hi = lo + $signed(COORD_W'(span));
    return (p >= lo) && (p < hi);
  endfunction

endpackage

// File: rtl/tree_bitmap_draw_if.sv
// Scanner-side bundle: scan coordinate, sprite anchor, frame/hit events and draw results.
// master = pixel scanner / frame logic, slave = tree_bitmap_draw.
interface tree_bitmap_draw_if import tree_pkg::*; ();

  logic [PIX_W-1:0]   pixelX;
  logic [PIX_W-1:0]   pixelY;
  logic [PIX_W-1:0]   topLeftX;
  logic [PIX_W-1:0]   topLeftY;
  logic               startOfFrame;
  logic               hit;
  logic               drawingRequest;
  logic [COLOR_W-1:0] RGBout;
  logic               shaking;

  modport master (
    output pixelX, pixelY, topLeftX, topLeftY, startOfFrame, hit,
    input  drawingRequest, RGBout, shaking
  );

  modport slave (
    input  pixelX, pixelY, topLeftX, topLeftY, startOfFrame, hit,
    output drawingRequest, RGBout, shaking
  );

endinterface

// File: rtl/tree_bitmap_draw_shake_fsm.sv
// Frame-synchronised horizontal shake after a hit; shift only moves on startOfFrame
// so a frame is never drawn with two different offsets.
module tree_shake_fsm #(
  parameter int SHAKE_FRAMES    = 16,
  parameter int SHAKE_PERIOD    = 4,
  parameter int SHAKE_AMPLITUDE = 2
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                hit,
  input  logic                                startOfFrame,
  output logic signed [tree_pkg::COORD_W-1:0] shift,
  output logic                                shaking
);
  import tree_pkg::*;

  localparam int CNT_W = $clog2(SHAKE_FRAMES + 1);
  localparam int PH_SH = $clog2(SHAKE_PERIOD);

  localparam logic signed [COORD_W-1:0] AMP_POS = $signed(COORD_W'(SHAKE_AMPLITUDE));
  localparam logic signed [COORD_W-1:0] AMP_NEG = -AMP_POS;
  localparam logic [CNT_W-1:0]          CNT_END = CNT_W'(SHAKE_FRAMES);

  shake_state_t              state;
  logic [CNT_W-1:0]          frame_cnt;
  logic signed [COORD_W-1:0] shift_q;
  logic [CNT_W-1:0]          phase;

  // Direction alternates every SHAKE_PERIOD frames: even phase pushes right.
  assign phase = frame_cnt >> PH_SH;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      frame_cnt <= '0;
      shift_q   <= '0;
      shaking   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state     <= SHAKE;
            frame_cnt <= '0;
            shaking   <= 1'b1;
          end
        end
        SHAKE: begin
          if (hit) begin
            frame_cnt <= '0;
            if (startOfFrame) shift_q <= AMP_POS;
          end else if (startOfFrame) begin
            if (frame_cnt == CNT_END) begin
              state     <= IDLE;
              frame_cnt <= '0;
              shift_q   <= '0;
              shaking   <= 1'b0;
            end else begin
              shift_q   <= phase[0] ? AMP_NEG : AMP_POS;
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          frame_cnt <= '0;
          shift_q   <= '0;
          shaking   <= 1'b0;
        end
      endcase
    end
  end

  assign shift = shift_q;

endmodule

// File: rtl/tree_bitmap_draw.sv
// Tree sprite pixel reader: stage 1 maps the scan coordinate to a sprite offset,
// stage 2 looks up the packed colour array and issues the draw request.
module tree_bitmap_draw #(
  parameter int         OBJECT_WIDTH_X       = tree_pkg::OBJECT_WIDTH_X,
  parameter int         OBJECT_HEIGHT_Y      = tree_pkg::OBJECT_HEIGHT_Y,
  parameter logic [7:0] TRANSPARENT_ENCODING = tree_pkg::TRANSPARENT_ENCODING,
  parameter int         SHAKE_FRAMES         = 16,
  parameter int         SHAKE_PERIOD         = 4,
  parameter int         SHAKE_AMPLITUDE      = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  tree_bitmap_draw_if.slave    bus,
  input  logic [0:OBJECT_HEIGHT_Y-1][0:OBJECT_WIDTH_X-1][7:0] object_colors
);
  import tree_pkg::*;

  localparam int OX_W = $clog2(OBJECT_WIDTH_X);
  localparam int OY_W = $clog2(OBJECT_HEIGHT_Y);

  logic signed [COORD_W-1:0] shift;
  logic signed [COORD_W-1:0] px, py, eff_left, top;
  logic                      inside_p0;
  logic [OX_W-1:0]           offx_p0;
  logic [OY_W-1:0]           offy_p0;

  logic                      inside_p1;
  logic [OX_W-1:0]           offx_p1;
  logic [OY_W-1:0]           offy_p1;
  logic [7:0]                color_p1;

  tree_shake_fsm #(
    .SHAKE_FRAMES    (SHAKE_FRAMES),
    .SHAKE_PERIOD    (SHAKE_PERIOD),
    .SHAKE_AMPLITUDE (SHAKE_AMPLITUDE)
  ) u_shake (
    .clk          (clk),
    .resetN       (resetN),
    .hit          (bus.hit),
    .startOfFrame (bus.startOfFrame),
    .shift        (shift),
    .shaking      (bus.shaking)
  );

  assign px       = to_coord(bus.pixelX);
  assign py       = to_coord(bus.pixelY);
  assign top      = to_coord(bus.topLeftY);
  assign eff_left = to_coord(bus.topLeftX) + shift;

  assign inside_p0 = in_span(px, eff_left, OBJECT_WIDTH_X) &&
                     in_span(py, top, OBJECT_HEIGHT_Y);

  // Low bits of a difference equal the difference of the low bits, so the
  // offsets are formed directly at sprite-index width.
  assign offx_p0 = OX_W'(px) - OX_W'(eff_left);
  assign offy_p0 = OY_W'(py) - OY_W'(top);

  // ---- stage 1: coordinate -> sprite offset ----
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) inside_p1 <= 1'b0;
    else         inside_p1 <= inside_p0;
  end

  always_ff @(posedge clk) begin
    offx_p1 <= offx_p0;
    offy_p1 <= offy_p0;
  end

  assign color_p1 = object_colors[offy_p1][offx_p1];

  // ---- stage 2: colour lookup -> draw request ----
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.drawingRequest <= 1'b0;
      bus.RGBout         <= TRANSPARENT_ENCODING;
    end else begin
      bus.drawingRequest <= inside_p1 && (color_p1 != TRANSPARENT_ENCODING);
      bus.RGBout         <= inside_p1 ? color_p1 : TRANSPARENT_ENCODING;
    end
  end

endmodule

// File: tb/tb_tree_bitmap_draw.sv
// Directed bench for tree_bitmap_draw: pipeline latency, sprite bounds, shake timing,
// left-edge handling and asynchronous reset, with hand-computed expectations.
module tb_tree_bitmap_draw;
  import tree_pkg::*;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  tree_colors_t colors;
  int           n_tests = 0;
  int           n_fail  = 0;

  tree_bitmap_draw_if bus();

  tree_bitmap_draw dut (
    .clk           (clk),
    .resetN        (resetN),
    .bus           (bus),
    .object_colors (colors)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int x, input int y);
    @(negedge clk);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input logic exp_dr, input logic [7:0] exp_rgb);
    set_pix(x, y);
    @(posedge clk);
    @(posedge clk);
    #1;
    check({tag, "_dr"}, 32'(bus.drawingRequest), 32'(exp_dr));
    check({tag, "_rgb"}, 32'(bus.RGBout), 32'(exp_rgb));
  endtask

  task automatic pulse(input logic h, input logic s);
    @(negedge clk);
    bus.hit = h;
    bus.startOfFrame = s;
    @(negedge clk);
    bus.hit = 1'b0;
    bus.startOfFrame = 1'b0;
  endtask

  task automatic sofs(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1);
  endtask

  initial begin
    for (int y = 0; y < OBJECT_HEIGHT_Y; y++)
      for (int x = 0; x < OBJECT_WIDTH_X; x++)
        colors[y][x] = TRANSPARENT_ENCODING;
    colors[0][11]  = 8'h91;
    colors[0][2]   = 8'h42;
    colors[0][1]   = 8'h77;
    colors[12][31] = 8'h95;

    bus.pixelX = '0;  bus.pixelY = '0;
    bus.topLeftX = 11'd100;  bus.topLeftY = 11'd200;
    bus.hit = 1'b0;  bus.startOfFrame = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dr", 32'(bus.drawingRequest), 32'd0);
    check("rst_rgb", 32'(bus.RGBout), 32'hFF);
    check("rst_shaking", 32'(bus.shaking), 32'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Transparent corner, then exact two-cycle latency to an opaque pixel
    probe("px100_200", 100, 200, 1'b0, 8'hFF);
    repeat (2) @(posedge clk);
    set_pix(111, 200);
    @(posedge clk); #1;
    check("lat1_dr", 32'(bus.drawingRequest), 32'd0);
    @(posedge clk); #1;
    check("lat2_dr", 32'(bus.drawingRequest), 32'd1);
    check("lat2_rgb", 32'(bus.RGBout), 32'h91);

    // Sprite bounds
    probe("left_out", 99, 200, 1'b0, 8'hFF);
    probe("right_out", 132, 200, 1'b0, 8'hFF);
    probe("bottom_out", 100, 232, 1'b0, 8'hFF);
    probe("row12_col31", 131, 212, 1'b1, 8'h95);

    // Shake: +2 for frames 0..3, -2 for 4..7, ends after 16 shifted frames
    pulse(1'b1, 1'b0);
    check("hit_shaking", 32'(bus.shaking), 32'd1);
    probe("hit_noshift", 111, 200, 1'b1, 8'h91);
    sofs(1);
    probe("shift_pos", 113, 200, 1'b1, 8'h91);
    probe("shift_pos_old", 111, 200, 1'b0, 8'hFF);
    sofs(3);
    probe("shift_pos_f3", 113, 200, 1'b1, 8'h91);
    sofs(1);
    probe("shift_neg", 109, 200, 1'b1, 8'h91);
    sofs(11);
    check("f16_shaking", 32'(bus.shaking), 32'd1);
    sofs(1);
    check("end_shaking", 32'(bus.shaking), 32'd0);
    probe("end_unshifted", 111, 200, 1'b1, 8'h91);

    // Left-edge: anchor at x=0 with shift -2
    pulse(1'b1, 1'b0);
    sofs(5);
    bus.topLeftX = 11'd0;
    probe("edge_x0", 0, 200, 1'b1, 8'h42);
    probe("edge_x2046", 2046, 200, 1'b0, 8'hFF);
    probe("edge_x2047", 2047, 200, 1'b0, 8'hFF);

    // Asynchronous reset mid-shake (frame 5), drawing active at that moment
    probe("prereset_dr", 0, 200, 1'b1, 8'h42);
    check("prereset_shaking", 32'(bus.shaking), 32'd1);
    #2 resetN = 1'b0;
    #1;
    check("arst_shaking", 32'(bus.shaking), 32'd0);
    check("arst_dr", 32'(bus.drawingRequest), 32'd0);
    check("arst_rgb", 32'(bus.RGBout), 32'hFF);
    @(negedge clk);
    resetN = 1'b1;
    bus.topLeftX = 11'd100;
    probe("postrst_unshift", 111, 200, 1'b1, 8'h91);
    probe("postrst_noshift", 113, 200, 1'b0, 8'hFF);

    // hit together with startOfFrame while IDLE: that frame stays unshifted
    pulse(1'b1, 1'b1);
    check("simul_shaking", 32'(bus.shaking), 32'd1);
    probe("simul_noshift", 111, 200, 1'b1, 8'h91);
    sofs(1);
    probe("simul_next_pos", 113, 200, 1'b1, 8'h91);

    // Re-trigger at frame 10: count restarts, so 3 frames later shift is still +2
    sofs(9);
    pulse(1'b1, 1'b0);
    sofs(3);
    probe("retrig_pos", 113, 200, 1'b1, 8'h91);
    sofs(2);
    probe("retrig_neg", 109, 200, 1'b1, 8'h91);

    // hit with startOfFrame while shaking: hit wins, shift forced to +2
    pulse(1'b1, 1'b1);
    probe("hitsof_pos", 113, 200, 1'b1, 8'h91);
    sofs(16);
    check("retrig_f16_shaking", 32'(bus.shaking), 32'd1);
    sofs(1);
    check("retrig_end_shaking", 32'(bus.shaking), 32'd0);
    probe("retrig_end_unshift", 111, 200, 1'b1, 8'h91);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
